// File: rtl/store_narrow.sv
// Store narrowing unit: encodes sw/sh/sb requests into word address, byte enables and
// lane-replicated data, buffered in a DEPTH-entry FIFO. Define ST_ALIGN_CHK_EN to drop misaligned sw/sh.
module store_narrow #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [31:0]            s_addr,
  input  logic [31:0]            s_wdata,
  input  logic [1:0]             s_op,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [31:0]            m_addr,
  output logic [3:0]             m_byteen,
  output logic [31:0]            m_wdata,
  output logic                   err,
  output logic [31:0]            err_addr,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   fifo_addr_q [DEPTH];
  logic [3:0]    fifo_be_q   [DEPTH];
  logic [31:0]   fifo_wd_q   [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_q, err_d;
  logic [31:0]   err_addr_q, err_addr_d;
  logic          accept, misalign, drop, push, pop;

  function automatic logic [3:0] enc_byteen(input logic [1:0] op, input logic [1:0] a);
    case (op)
      2'b00:   return 4'b1111;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b0001 << a;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] enc_wdata(input logic [1:0] op, input logic [31:0] d);
    case (op)
      2'b00:   return d;
      2'b01:   return {2{d[15:0]}};
      2'b10:   return {4{d[7:0]}};
      default: return 32'h0;
    endcase
  endfunction

  assign s_ready = (count_q != CW'(DEPTH));
  assign m_valid = (count_q != '0);

  always_comb begin
    accept = s_valid && s_ready;
`ifdef ST_ALIGN_CHK_EN
    misalign = ((s_op == 2'b00) && (s_addr[1:0] != 2'b00)) ||
               ((s_op == 2'b01) && s_addr[0]);
`else
    misalign = 1'b0;
`endif
    drop       = accept && ((s_op == 2'b11) || misalign);
    push       = accept && !drop;
    pop        = m_valid && m_ready;
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    err_d      = drop;
    err_addr_d = drop ? s_addr : err_addr_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Encoding happens once at accept; the FIFO holds the final memory-side fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_be_q[i]   <= '0;
        fifo_wd_q[i]   <= '0;
      end
    end else if (push) begin
      fifo_addr_q[wr_ptr_q] <= {s_addr[31:2], 2'b00};
      fifo_be_q[wr_ptr_q]   <= enc_byteen(s_op, s_addr[1:0]);
      fifo_wd_q[wr_ptr_q]   <= enc_wdata(s_op, s_wdata);
    end
  end

  assign m_addr   = m_valid ? fifo_addr_q[rd_ptr_q] : '0;
  assign m_byteen = m_valid ? fifo_be_q[rd_ptr_q]   : '0;
  assign m_wdata  = m_valid ? fifo_wd_q[rd_ptr_q]   : '0;
  assign err      = err_q;
  assign err_addr = err_addr_q;
  assign count    = count_q;

endmodule
